// File: rtl/ppu_pkg.sv
// Shared types and constants for the PPU VRAM arbiter: response tags, owner states,
// PPU mode encodings and the VRAM window base.
package ppu_pkg;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_BG   = 2'd1,
        TAG_SPR  = 2'd2,
        TAG_CPU  = 2'd3
    } vram_tag_e;

    typedef enum logic [1:0] {
        OWN_BG    = 2'd0,
        OWN_DRAIN = 2'd1,
        OWN_SPR   = 2'd2
    } owner_e;

    localparam logic [1:0] MODE_HBLANK = 2'd0;
    localparam logic [1:0] MODE_VBLANK = 2'd1;
    localparam logic [1:0] MODE_OAM    = 2'd2;
    localparam logic [1:0] MODE_DRAW   = 2'd3;

    localparam logic [15:0] VRAM_BASE        = 16'h8000;
    localparam logic [7:0]  VRAM_LOCKED_READ = 8'hFF;

endpackage

// File: rtl/vram_tag_pipe.sv
// Response tag shift register (one stage per cycle of memory latency) plus a count of
// reads still waiting for their data.
module vram_tag_pipe
    import ppu_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  vram_tag_e       push_tag_i,
    output vram_tag_e       tag_o,
    output logic [CW-1:0]   inflight_o
);

    vram_tag_e     tag_q [DEPTH];
    vram_tag_e     tag_d [DEPTH];
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push_rd, pop_rd;

    // Writes push TAG_NONE, so any non-NONE tag is a read with data coming back.
    assign push_rd    = (push_tag_i != TAG_NONE);
    assign pop_rd     = (tag_q[DEPTH-1] != TAG_NONE);
    assign tag_o      = tag_q[DEPTH-1];
    assign inflight_o = cnt_q;

    always_comb begin
        tag_d[0] = push_tag_i;
        for (int i = 1; i < DEPTH; i++) tag_d[i] = tag_q[i-1];
        cnt_d = cnt_q;
        if (push_rd && !pop_rd)      cnt_d = cnt_q + CW'(1);
        else if (!push_rd && pop_rd) cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) tag_q[i] <= TAG_NONE;
            cnt_q <= '0;
        end else begin
            tag_q <= tag_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ppu_vram_arbiter.sv
// Shares the VRAM port between background fetcher, sprite fetcher and CPU, with the
// mode-3 CPU lock and sprite hand-off. Optional perf counters: define VRAM_ARB_PERF_EN.
module ppu_vram_arbiter
    import ppu_pkg::*;
#(
    parameter int MEM_LATENCY = 2,
    parameter int ADDR_W      = 16
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [1:0]        ppu_mode_in,
    input  logic [ADDR_W-1:0] bg_addr_in,
    input  logic              bg_req_in,
    output logic              bg_gnt_out,
    output logic [7:0]        bg_data_out,
    output logic              bg_data_valid_out,
    input  logic              bg_busy_in,
    input  logic [ADDR_W-1:0] spr_addr_in,
    input  logic              spr_req_in,
    output logic              spr_gnt_out,
    output logic [7:0]        spr_data_out,
    output logic              spr_data_valid_out,
    input  logic              sprite_hit_in,
    input  logic              sprite_done_in,
    output logic              spr_owner_out,
    input  logic [ADDR_W-1:0] cpu_addr_in,
    input  logic [7:0]        cpu_wdata_in,
    input  logic              cpu_we_in,
    input  logic              cpu_req_in,
    output logic              cpu_ack_out,
    output logic [7:0]        cpu_rdata_out,
    output logic [12:0]       mem_addr_out,
    output logic              mem_en_out,
    output logic              mem_we_out,
    output logic [7:0]        mem_wdata_out,
    input  logic [7:0]        mem_data_in
`ifdef VRAM_ARB_PERF_EN
    ,
    output logic [15:0]       cpu_block_cnt_out,
    output logic [15:0]       drain_cnt_out
`endif
);

    localparam int CW = $clog2(MEM_LATENCY + 1);

    owner_e            own_q, own_d;
    vram_tag_e         tag_out, resp_tag, push_tag;
    logic [CW-1:0]     inflight;
    logic              cpu_pend_q, cpu_pend_d;
    logic              ack_q, ack_d, ack_ff_q, ack_ff_d;
    logic              bg_go, spr_go, cpu_eval, cpu_go, lock_go, drained;
    logic [ADDR_W-1:0] sel_addr;

    vram_tag_pipe #(.DEPTH(MEM_LATENCY)) u_tags (
        .clk_i      (clk_in),
        .rst_i      (rst_in),
        .push_tag_i (push_tag),
        .tag_o      (tag_out),
        .inflight_o (inflight)
    );

    assign resp_tag = rst_in ? TAG_NONE : tag_out;
    assign drained  = (inflight == '0) && !bg_busy_in;

    always_comb begin
        own_d    = own_q;
        push_tag = TAG_NONE;
        sel_addr = ADDR_W'(VRAM_BASE);
        case (own_q)
            OWN_BG:    if (sprite_hit_in)  own_d = OWN_DRAIN;
            OWN_DRAIN: if (drained)        own_d = OWN_SPR;
            OWN_SPR:   if (sprite_done_in) own_d = OWN_BG;
            default:                       own_d = OWN_BG;
        endcase

        // Background yields in the very cycle the hit is reported.
        bg_go    = !rst_in && bg_req_in && (own_q == OWN_BG) && !sprite_hit_in;
        spr_go   = !rst_in && spr_req_in && (own_q == OWN_SPR);
        cpu_eval = !rst_in && cpu_req_in && !cpu_pend_q;
        lock_go  = cpu_eval && (ppu_mode_in == MODE_DRAW);
        cpu_go   = cpu_eval && !lock_go && !bg_go && !spr_go;

        if (bg_go) begin
            push_tag = TAG_BG;
            sel_addr = bg_addr_in;
        end else if (spr_go) begin
            push_tag = TAG_SPR;
            sel_addr = spr_addr_in;
        end else if (cpu_go) begin
            sel_addr = cpu_addr_in;
            if (!cpu_we_in) push_tag = TAG_CPU;
        end

        // The CPU request stays high through its ack cycle, so keep it blocked until then.
        cpu_pend_d = (cpu_pend_q && !cpu_ack_out) || cpu_go || lock_go;
        ack_d      = (cpu_go && cpu_we_in) || lock_go;
        ack_ff_d   = lock_go && !cpu_we_in;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            own_q      <= OWN_BG;
            cpu_pend_q <= 1'b0;
            ack_q      <= 1'b0;
            ack_ff_q   <= 1'b0;
        end else begin
            own_q      <= own_d;
            cpu_pend_q <= cpu_pend_d;
            ack_q      <= ack_d;
            ack_ff_q   <= ack_ff_d;
        end
    end

    assign mem_en_out    = bg_go || spr_go || cpu_go;
    assign mem_we_out    = cpu_go && cpu_we_in;
    assign mem_wdata_out = mem_we_out ? cpu_wdata_in : 8'h00;
    assign mem_addr_out  = 13'(sel_addr - ADDR_W'(VRAM_BASE));

    assign bg_gnt_out         = bg_go;
    assign spr_gnt_out        = spr_go;
    assign bg_data_valid_out  = (resp_tag == TAG_BG);
    assign spr_data_valid_out = (resp_tag == TAG_SPR);
    assign bg_data_out        = bg_data_valid_out  ? mem_data_in : 8'h00;
    assign spr_data_out       = spr_data_valid_out ? mem_data_in : 8'h00;
    assign spr_owner_out      = !rst_in && (own_q == OWN_SPR);

    assign cpu_ack_out   = (ack_q && !rst_in) || (resp_tag == TAG_CPU);
    assign cpu_rdata_out = (resp_tag == TAG_CPU)   ? mem_data_in :
                           (ack_ff_q && !rst_in)   ? VRAM_LOCKED_READ : 8'h00;

`ifdef VRAM_ARB_PERF_EN
    logic [15:0] cpu_block_q, drain_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cpu_block_q <= 16'h0000;
            drain_q     <= 16'h0000;
        end else begin
            if (cpu_req_in && !cpu_go && (cpu_block_q != 16'hFFFF))
                cpu_block_q <= cpu_block_q + 16'd1;
            if ((own_q == OWN_DRAIN) && (drain_q != 16'hFFFF))
                drain_q <= drain_q + 16'd1;
        end
    end

    assign cpu_block_cnt_out = cpu_block_q;
    assign drain_cnt_out     = drain_q;
`endif

endmodule

// File: tb/tb_ppu_vram_arbiter.sv
// Bench for ppu_vram_arbiter: vector table, directed hand-off / back-to-back / reset
// sequences, then random traffic against a timestamp-queue reference model.
module tb_ppu_vram_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic [15:0] bg_addr, spr_addr, cpu_addr;
    logic        bg_req, bg_busy, spr_req, hit, done, cpu_req, cpu_we;
    logic [7:0]  cpu_wd, mem_data;
    logic        bg_gnt, bg_dv, spr_gnt, spr_dv, spr_owner, cpu_ack, mem_en, mem_we;
    logic [7:0]  bg_data, spr_data, cpu_rdata, mem_wdata;
    logic [12:0] mem_addr;
`ifdef VRAM_ARB_PERF_EN
    logic [15:0] blk_cnt, drn_cnt;
`endif

    always #5 clk = ~clk;

    ppu_vram_arbiter #(.MEM_LATENCY(LAT), .ADDR_W(16)) dut (
        .clk_in(clk), .rst_in(rst), .ppu_mode_in(mode),
        .bg_addr_in(bg_addr), .bg_req_in(bg_req), .bg_gnt_out(bg_gnt),
        .bg_data_out(bg_data), .bg_data_valid_out(bg_dv), .bg_busy_in(bg_busy),
        .spr_addr_in(spr_addr), .spr_req_in(spr_req), .spr_gnt_out(spr_gnt),
        .spr_data_out(spr_data), .spr_data_valid_out(spr_dv),
        .sprite_hit_in(hit), .sprite_done_in(done), .spr_owner_out(spr_owner),
        .cpu_addr_in(cpu_addr), .cpu_wdata_in(cpu_wd), .cpu_we_in(cpu_we),
        .cpu_req_in(cpu_req), .cpu_ack_out(cpu_ack), .cpu_rdata_out(cpu_rdata),
        .mem_addr_out(mem_addr), .mem_en_out(mem_en), .mem_we_out(mem_we),
        .mem_wdata_out(mem_wdata), .mem_data_in(mem_data)
`ifdef VRAM_ARB_PERF_EN
        , .cpu_block_cnt_out(blk_cnt), .drain_cnt_out(drn_cnt)
`endif
    );

    int errs = 0, checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mode = 2'd0; bg_addr = 16'h8000; bg_req = 0; bg_busy = 0;
        spr_addr = 16'h8000; spr_req = 0; hit = 0; done = 0;
        cpu_addr = 16'h8000; cpu_wd = 8'h00; cpu_we = 0; cpu_req = 0; mem_data = 8'h00;
    endtask

    task automatic chk_quiet(input string name);
        chk(name, {16'h0, mem_en, mem_we, bg_gnt, spr_gnt, bg_dv, spr_dv, cpu_ack, spr_owner, cpu_rdata}, 32'h0);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  mode;
        logic        bg_req;
        logic [15:0] bg_addr;
        logic        cpu_req, cpu_we;
        logic [15:0] cpu_addr;
        logic [7:0]  cpu_wd;
        logic        e_en, e_we, e_gnt;
        logic [12:0] e_addr;
        logic [7:0]  e_wd;
        int          r_kind;   // 1: background data strobe, 2: CPU ack
        int          r_dly;
        logic [7:0]  r_data;
    } vec_t;

    vec_t vt [8];

    // Reference model state (random phase)
    typedef struct { int due; int who; } resp_t;
    resp_t       rq[$];
    int          cyc, own, side_cyc, who_now;
    bit          cpu_open, side_ff, drained;
    bit          e_bg, e_spr, e_cev, e_lock, e_cpu, e_ack, e_en, e_we;
    logic [7:0]  e_rd, e_wd;
    logic [12:0] e_addr;

    task automatic push_resp(input int due, input int who);
        resp_t r;
        r.due = due;
        r.who = who;
        rq.push_back(r);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        bg_req = 1; cpu_req = 1; mode = 2'd0;
        @(negedge clk);
        chk_quiet("reset held with requests");
        tick();
        idle_inputs();
        rst = 1'b0;
        @(negedge clk);
        chk_quiet("after reset idle");
        tick();

        vt[0] = '{2'd3, 1, 16'h9800, 0, 0, 16'h8000, 8'h00, 1, 0, 1, 13'h1800, 8'h00, 1, LAT, 8'h3C};
        vt[1] = '{2'd3, 0, 16'h8000, 1, 0, 16'h8010, 8'h00, 0, 0, 0, 13'h0000, 8'h00, 2, 1,   8'hFF};
        vt[2] = '{2'd3, 0, 16'h8000, 1, 1, 16'h8020, 8'h77, 0, 0, 0, 13'h0000, 8'h00, 2, 1,   8'h00};
        vt[3] = '{2'd0, 0, 16'h8000, 1, 1, 16'h8000, 8'h5A, 1, 1, 0, 13'h0000, 8'h5A, 2, 1,   8'h00};
        vt[4] = '{2'd1, 0, 16'h8000, 1, 0, 16'h9FFF, 8'h00, 1, 0, 0, 13'h1FFF, 8'h00, 2, LAT, 8'h3C};
        vt[5] = '{2'd2, 1, 16'h8123, 1, 0, 16'h8001, 8'h00, 1, 0, 1, 13'h0123, 8'h00, 1, LAT, 8'h3C};
        vt[6] = '{2'd0, 0, 16'h8000, 1, 1, 16'h9ABC, 8'hA5, 1, 1, 0, 13'h1ABC, 8'hA5, 2, 1,   8'h00};
        vt[7] = '{2'd3, 1, 16'h9FFF, 1, 0, 16'h8000, 8'h00, 1, 0, 1, 13'h1FFF, 8'h00, 2, 1,   8'hFF};

        for (int i = 0; i < 8; i++) begin
            do_reset();
            mem_data = 8'h3C;
            mode = vt[i].mode; bg_req = vt[i].bg_req; bg_addr = vt[i].bg_addr;
            cpu_req = vt[i].cpu_req; cpu_we = vt[i].cpu_we;
            cpu_addr = vt[i].cpu_addr; cpu_wd = vt[i].cpu_wd;
            @(negedge clk);
            chk($sformatf("v%0d issue", i), {mem_en, mem_we, bg_gnt, mem_addr, mem_wdata},
                {vt[i].e_en, vt[i].e_we, vt[i].e_gnt, vt[i].e_addr, vt[i].e_wd});
            tick();
            bg_req = 0; cpu_req = 0;
            for (int d = 1; d <= vt[i].r_dly; d++) begin
                @(negedge clk);
                if (vt[i].r_kind == 1) begin
                    chk($sformatf("v%0d bg strobe d%0d", i, d), bg_dv, d == vt[i].r_dly);
                    if (d == vt[i].r_dly) chk($sformatf("v%0d bg data", i), bg_data, vt[i].r_data);
                end else begin
                    chk($sformatf("v%0d cpu ack d%0d", i, d), cpu_ack, d == vt[i].r_dly);
                    if (d == vt[i].r_dly && !vt[i].cpu_we)
                        chk($sformatf("v%0d cpu rdata", i), cpu_rdata, vt[i].r_data);
                end
                chk($sformatf("v%0d no write", i), mem_we, 1'b0);
                tick();
            end
        end

        // Sprite hit while a background read is in flight
        do_reset();
        mode = 2'd3; bg_busy = 1; mem_data = 8'hB1; bg_req = 1; bg_addr = 16'h9800;
        @(negedge clk); chk("ho bg gnt", bg_gnt, 1);
        tick(); bg_req = 0; hit = 1;
        @(negedge clk); chk("ho owner at hit", spr_owner, 0);
        tick(); hit = 0; spr_req = 1; spr_addr = 16'h8A00;
        @(negedge clk); chk("ho bg resp", {bg_dv, bg_data}, {1'b1, 8'hB1});
        chk("ho drain no spr gnt", {spr_gnt, spr_owner}, 2'b00);
        tick();
        @(negedge clk); chk("ho busy holds drain", {spr_gnt, spr_owner}, 2'b00);
        tick(); bg_busy = 0;
        @(negedge clk); chk("ho drained cycle", {spr_gnt, spr_owner}, 2'b00);
        tick();
        @(negedge clk); chk("ho spr own+gnt", {spr_owner, spr_gnt, mem_en, mem_addr}, {3'b111, 13'h0A00});
        tick(); spr_req = 0; bg_req = 1; bg_addr = 16'h9801; mem_data = 8'hC2;
        @(negedge clk); chk("ho bg blocked", bg_gnt, 0);
        tick();
        @(negedge clk); chk("ho spr resp", {spr_dv, spr_data, bg_gnt}, {1'b1, 8'hC2, 1'b0});
        tick(); done = 1;
        @(negedge clk); chk("ho done cycle", {bg_gnt, spr_owner}, 2'b01);
        tick(); done = 0;
        @(negedge clk); chk("ho bg back", {bg_gnt, spr_owner, mem_addr}, {2'b10, 13'h1801});
        tick(); bg_req = 0;

        // Same-cycle background and CPU read in mode 2
        do_reset();
        mode = 2'd2; bg_req = 1; bg_addr = 16'h9000;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h8555; mem_data = 8'h11;
        @(negedge clk); chk("b2b bg first", {bg_gnt, mem_addr, cpu_ack}, {1'b1, 13'h1000, 1'b0});
        tick(); bg_req = 0; mem_data = 8'h22;
        @(negedge clk); chk("b2b cpu issue", {mem_en, mem_we, bg_gnt, mem_addr}, {3'b100, 13'h0555});
        tick(); mem_data = 8'h33;
        @(negedge clk); chk("b2b bg resp", {bg_dv, bg_data, cpu_ack}, {1'b1, 8'h33, 1'b0});
        tick(); mem_data = 8'h44;
        @(negedge clk); chk("b2b cpu resp", {cpu_ack, cpu_rdata, bg_dv, mem_en}, {1'b1, 8'h44, 2'b00});
        tick(); cpu_req = 0;
        @(negedge clk); chk("b2b ack single", cpu_ack, 0);
        tick();

        // Reset with two reads in flight
        do_reset();
        bg_req = 1; bg_addr = 16'h9000;
        @(negedge clk); chk("rst bg gnt", bg_gnt, 1);
        tick(); bg_req = 0; cpu_req = 1; cpu_addr = 16'h8100;
        @(negedge clk); chk("rst cpu issue", mem_en, 1);
        tick(); rst = 1; mem_data = 8'h99;
        @(negedge clk); chk_quiet("rst mid-flight");
        tick(); rst = 0; cpu_req = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); chk_quiet($sformatf("rst drop c%0d", k));
            tick();
        end

        // Random traffic against the reference model
        do_reset();
        rq.delete(); cyc = 0; own = 0; cpu_open = 0; side_cyc = -1; side_ff = 0;
        for (int n = 0; n < 3000; n++) begin
            mem_data = 8'($urandom);
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
            bg_busy = ($urandom_range(0, 2) == 0);
            hit     = ($urandom_range(0, 15) == 0);
            done    = ($urandom_range(0, 7) == 0);
            if (!bg_req && $urandom_range(0, 2) == 0) begin
                bg_req = 1; bg_addr = 16'h8000 + 16'($urandom_range(0, 16'h1FFF));
            end
            if (!spr_req && $urandom_range(0, 2) == 0) begin
                spr_req = 1; spr_addr = 16'h8000 + 16'($urandom_range(0, 16'h1FFF));
            end
            if (!cpu_req && $urandom_range(0, 2) == 0) begin
                cpu_req = 1; cpu_we = 1'($urandom_range(0, 1)); cpu_wd = 8'($urandom);
                cpu_addr = 16'h8000 + 16'($urandom_range(0, 16'h1FFF));
            end
            @(negedge clk);
            who_now = (rq.size() > 0 && rq[0].due == cyc) ? rq[0].who : 0;
            e_bg    = (own == 0) && !hit && bg_req;
            e_spr   = (own == 2) && spr_req;
            e_cev   = cpu_req && !cpu_open;
            e_lock  = e_cev && (mode == 2'd3);
            e_cpu   = e_cev && (mode != 2'd3) && !e_bg && !e_spr;
            e_ack   = (who_now == 3) || (side_cyc == cyc);
            e_rd    = (who_now == 3) ? mem_data : (side_cyc == cyc && side_ff) ? 8'hFF : 8'h00;
            e_en    = e_bg || e_spr || e_cpu;
            e_we    = e_cpu && cpu_we;
            e_wd    = e_we ? cpu_wd : 8'h00;
            e_addr  = e_bg ? 13'(bg_addr - 16'h8000) : e_spr ? 13'(spr_addr - 16'h8000) :
                      e_cpu ? 13'(cpu_addr - 16'h8000) : 13'h0;
            chk($sformatf("rnd%0d grants", n), {bg_gnt, spr_gnt}, {e_bg, e_spr});
            chk($sformatf("rnd%0d mem", n), {mem_en, mem_we, mem_addr, mem_wdata}, {e_en, e_we, e_addr, e_wd});
            chk($sformatf("rnd%0d ppu data", n), {bg_dv, bg_data, spr_dv, spr_data},
                {who_now == 1, (who_now == 1) ? mem_data : 8'h00, who_now == 2, (who_now == 2) ? mem_data : 8'h00});
            chk($sformatf("rnd%0d cpu", n), {cpu_ack, cpu_rdata}, {e_ack, e_rd});
            chk($sformatf("rnd%0d owner", n), spr_owner, own == 2);
            drained = (rq.size() == 0) && !bg_busy;
            @(posedge clk);
            if (who_now != 0) void'(rq.pop_front());
            if (e_bg)  push_resp(cyc + LAT, 1);
            if (e_spr) push_resp(cyc + LAT, 2);
            if (e_cpu && !cpu_we) push_resp(cyc + LAT, 3);
            if (e_ack) cpu_open = 0;
            if (e_lock || e_cpu) begin
                cpu_open = 1;
                if (e_lock || cpu_we) begin
                    side_cyc = cyc + 1;
                    side_ff  = e_lock && !cpu_we;
                end
            end
            case (own)
                0: if (hit) own = 1;
                1: if (drained) own = 2;
                default: if (done) own = 0;
            endcase
            cyc++;
            #1;
            if (e_bg)  bg_req = 0;
            if (e_spr) spr_req = 0;
            if (e_ack) cpu_req = 0;
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/ppu_vram_arbiter.md
Name: ppu_vram_arbiter

Overview:
- Sequences and shares the single VRAM read/write port between the background fetcher (feeding the background FIFO), the sprite fetcher and the CPU.
- Enforces DMG VRAM locking during PPU mode 3.
- Performs the background-to-sprite ownership hand-off on a sprite hit.
- Routes read data back to the issuing requester after a fixed memory latency.

Parameters:
- MEM_LATENCY, 2, cycles from mem_addr_out issue to mem_data_in valid (1..4)
- ADDR_W, 16, address width (CPU-visible VRAM address, 0x8000-0x9FFF)

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous, active-high reset
- ppu_mode_in  in  2  current PPU mode (0 HBlank, 1 VBlank, 2 OAM, 3 draw)
- bg_addr_in  in  ADDR_W  background fetcher read address
- bg_req_in  in  1  background read request, held until bg_gnt_out
- bg_gnt_out  out  1  one-cycle grant pulse
- bg_data_out  out  8  background read data
- bg_data_valid_out  out  1  background data strobe
- bg_busy_in  in  1  background fetcher mid-fetch (mem_busy)
- spr_addr_in  in  ADDR_W  sprite fetcher read address
- spr_req_in  in  1  sprite read request, held until spr_gnt_out
- spr_gnt_out  out  1  one-cycle grant pulse
- spr_data_out  out  8  sprite read data
- spr_data_valid_out  out  1  sprite data strobe
- sprite_hit_in  in  1  sprite hit; background must yield
- sprite_done_in  in  1  sprite fetch complete pulse
- spr_owner_out  out  1  sprite fetcher owns VRAM
- cpu_addr_in  in  ADDR_W  CPU address
- cpu_wdata_in  in  8  CPU write data
- cpu_we_in  in  1  CPU write, else read
- cpu_req_in  in  1  CPU request, held until cpu_ack_out
- cpu_ack_out  out  1  CPU completion pulse
- cpu_rdata_out  out  8  CPU read data, valid with cpu_ack_out
- mem_addr_out  out  13  VRAM offset (ADDR_W address minus 0x8000)
- mem_en_out  out  1  VRAM access strobe
- mem_we_out  out  1  VRAM write enable
- mem_wdata_out  out  8  VRAM write data
- mem_data_in  in  8  VRAM read data, valid MEM_LATENCY cycles after issue

Behaviour:
- Reset:
  - All outputs 0; cpu_rdata_out = 0x00.
  - State BG_OWN; tag pipeline cleared; in-flight count 0.
  - Reset mid-transaction drops all in-flight responses; no data_valid after reset.
- Ownership FSM states:
  - BG_OWN: background is the eligible PPU requester.
  - DRAIN: no new PPU issues; waiting for in-flight count 0 and bg_busy_in low.
  - SPR_OWN: sprite is the eligible PPU requester; spr_owner_out = 1.
- FSM transitions:
  - BG_OWN -> DRAIN on sprite_hit_in.
  - DRAIN -> SPR_OWN when drained.
  - SPR_OWN -> BG_OWN on sprite_done_in.
  - sprite_hit_in while in DRAIN or SPR_OWN is ignored.
  - sprite_done_in outside SPR_OWN is ignored.
- Issue rules:
  - At most one access per cycle.
  - Priority: the eligible PPU requester, then CPU.
  - Grant pulse and mem_en_out occur in the same cycle.
  - A request seen in cycle N is granted no earlier than cycle N (combinational grant, registered memory outputs permitted).
- CPU lock:
  - When ppu_mode_in == 3, the CPU is never issued to memory.
  - CPU read: cpu_ack_out pulses one cycle after request, cpu_rdata_out = 0xFF.
  - CPU write: acked one cycle after request and discarded; mem_we_out stays 0.
- CPU access in modes 0-2:
  - Issued when no PPU request wins.
  - Write: acked the cycle after issue.
  - Read: acked together with the data, MEM_LATENCY cycles after issue.
  - Only one CPU transaction outstanding.
- Response routing:
  - Each issue pushes a 2-bit tag (NONE/BG/SPR/CPU) into a MEM_LATENCY-deep shift register.
  - The tag at the output selects which data_valid/ack pulses with mem_data_in.
  - Responses are never reordered.
- In-flight counter:
  - Range 0..MEM_LATENCY.
  - Increments on read issue, decrements on response.
  - Simultaneous issue and response: counter unchanged.
- Mode 3 exit while a locked CPU request is pending: request is handled under the mode sampled at the cycle it is evaluated.

Optional Feature:
- Macro VRAM_ARB_PERF_EN.
- Defined:
  - Adds outputs cpu_block_cnt_out[15:0] (cycles with cpu_req_in high and not issued) and drain_cnt_out[15:0] (cycles in DRAIN).
  - Both saturate at 0xFFFF and clear on reset.
- Undefined: ports and counters absent; no other behavioural difference.

Decomposition:
- Package ppu_pkg:
  - Tag enum (TAG_NONE, TAG_BG, TAG_SPR, TAG_CPU).
  - Owner-state enum.
  - PPU mode constants (MODE_HBLANK..MODE_DRAW).
  - VRAM_BASE = 16'h8000.
  - VRAM_LOCKED_READ = 8'hFF.
- Sub-module vram_tag_pipe: parameterised-depth tag shift register plus in-flight counter.

Test Plan:
- Reset then bg_req_in with addr 0x9800, MEM_LATENCY=2:
  - bg_gnt_out and mem_addr_out=0x1800 in the same cycle.
  - bg_data_valid_out exactly 2 cycles later carrying mem_data_in.
- Mode 3, CPU read of 0x8010:
  - cpu_ack_out one cycle later with 0xFF; mem_en_out never asserted.
- Mode 3, CPU write: acked, mem_we_out stays 0.
- Mode 0, CPU write 0x8000 = 0x5A:
  - mem_we_out=1, mem_addr_out=0, mem_wdata_out=0x5A.
  - Ack next cycle.
- Background read in flight, sprite_hit_in pulses:
  - State DRAIN until the response returns and bg_busy_in falls.
  - Then spr_owner_out=1; spr_req_in granted.
  - bg_req_in held during SPR_OWN is not granted until after sprite_done_in.
- Same-cycle bg_req_in and cpu_req_in in mode 2:
  - Background granted first, CPU the next cycle.
  - Tags route both responses correctly, back-to-back.
- Assert rst_in with 2 reads in flight: no data_valid/ack pulses afterwards; outputs 0.
